clock_ctrl: RTL
===============

// Module: clock_ctrl
// PURPOSE
//  Sequencer for the seconds/minutes/hours bcd counter chain of the 7-segment clock.
//  - Generates the 1 Hz tick from clk_i.
//  - Routes carries between the counters and runs the time-set mode FSM (mode/adjust buttons).
//  - Drives every counter's increment input, so counter blocks never see raw button or tick logic.
// PARAMETERS
//  CLK_HZ      10000  clk_i cycles per second; prescaler period (>=4, even)
//  REPEAT_CYC  2500   auto-repeat period in cycles while adj_i is held in a SET state (>=2)
// PORTS
//  clk_i       in   1  clock; all state updates on posedge
//  rst_ni      in   1  synchronous reset, active low
//  mode_i      in   1  mode button, synchronised + debounced, 1-cycle pulse per press
//  adj_i       in   1  adjust button, synchronised + debounced level (1 = held)
//  sec_ovf_i   in   1  seconds counter overflow_o (already qualified by its increment)
//  min_ovf_i   in   1  minutes counter overflow_o
//  sec_inc_o   out  1  seconds counter increment
//  min_inc_o   out  1  minutes counter increment
//  hr_inc_o    out  1  hours counter increment
//  sec_clr_o   out  1  seconds counter synchronous clear, 1-cycle pulse
//  tick_o      out  1  1 Hz pulse, one cycle wide
//  state_o     out  2  FSM state: 0 RUN, 1 SET_HR, 2 SET_MIN (3 unused)
//  blink_o     out  1  display blank strobe for the field being set
// BEHAVIOUR
//  Reset (rst_ni=0 at a posedge), in the following cycle:
//  - state RUN, prescaler 0, rep_cnt 0, adj_q 0
//  - all registered outputs 0; no pulses on sec_clr_o or adj-derived incs
//  - reset mid-SET abandons the set; counter values are untouched
//  Prescaler:
//  - free-runs 0..CLK_HZ-1 in every state, wraps to 0
//  - tick_o is registered: 1 in the cycle after presc==CLK_HZ-1
//  - first tick after reset lands at cycle CLK_HZ
//  - forced to 0 on the cycle sec_clr_o is issued
//  FSM (advances only on mode_i):
//  - RUN -> SET_HR -> SET_MIN -> RUN
//  - on SET_MIN->RUN: sec_clr_o=1 next cycle; prescaler restarts so the next tick is CLK_HZ cycles later
//  - outputs in the transition cycle follow the current (old) state
//  RUN (all combinational, zero latency):
//  - sec_inc_o=tick_o
//  - min_inc_o=sec_ovf_i
//  - hr_inc_o=min_ovf_i
//  SET_HR / SET_MIN:
//  - sec_inc_o=0; overflow pass-through suppressed (no carry, minutes wrap never bumps hours)
//  - only the selected field gets adj pulses; the other inc output stays 0
//  Adjust pulses (registered):
//  - selected inc =1 at cycle n+1 iff at cycle n: adj_i=1, state is SET_x, mode_i=0, and (adj_i & ~adj_q | rep_cnt==REPEAT_CYC-1)
//  - rep_cnt: next=0 on rising edge or when at REPEAT_CYC-1; else +1 while adj_i held; 0 when released
//  - adj_q <= adj_i every cycle, including when mode_i wins
//  - mode_i and adj pulse condition in same cycle: mode wins, no adj inc
//  blink_o:
//  - registered; = (state!=RUN) & (presc < CLK_HZ/2)
//  - 0 in RUN
// TESTING
//  1. CLK_HZ=10, release reset at c0 -> tick_o and sec_inc_o high at c10, c20, c30; all else 0; state_o=0.
//  2. RUN: sec_ovf_i=1 on tick cycle -> min_inc_o=1 same cycle. Drive min_ovf_i=1 -> hr_inc_o=1. SET_HR: same stimulus -> both 0.
//  3. Three mode_i pulses at c3, c8, c12 -> state_o 1 from c4, 2 from c9, 0 from c13; sec_clr_o=1 at c13 only; next tick_o at c23.
//  4. SET_MIN, adj_i high 1 cycle, min_ovf_i=1 -> exactly one min_inc_o pulse next cycle; hr_inc_o, sec_inc_o stay 0.
//  5. SET_HR, REPEAT_CYC=4, adj_i high c0..c12 -> hr_inc_o pulses at c1, c5, c9, c13 only.
//  6. SET_MIN with adj_i held, rst_ni=0 at c5 -> from c6: state_o=0, all incs/blink 0; after release, tick at CLK_HZ.

Source files
------------

// File: rtl/clock_ctrl.sv
// clock_ctrl: 1 Hz prescaler, carry routing and time-set mode FSM for the
// seconds/minutes/hours BCD counter chain of the 7-segment clock.
module clock_ctrl #(
    parameter int unsigned CLK_HZ     = 10000,
    parameter int unsigned REPEAT_CYC = 2500
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       mode_i,
    input  logic       adj_i,
    input  logic       sec_ovf_i,
    input  logic       min_ovf_i,
    output logic       sec_inc_o,
    output logic       min_inc_o,
    output logic       hr_inc_o,
    output logic       sec_clr_o,
    output logic       tick_o,
    output logic [1:0] state_o,
    output logic       blink_o
);

    localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned RW = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2
    } state_e;

    state_e          state_q;
    logic [PW-1:0]   presc_q, presc_d;
    logic [RW-1:0]   rep_cnt_q, rep_cnt_d;
    logic            adj_q;
    logic            tick_q;
    logic            sec_clr_q;
    logic            hr_adj_q;
    logic            min_adj_q;
    logic            blink_q;

    logic            leave_set;
    logic            presc_wrap;
    logic            adj_rise;
    logic            rep_hit;
    logic            adj_fire;
    logic            blink_win;

    // Next-state datapath: prescaler, auto-repeat counter, adjust qualifier
    always_comb begin
        leave_set  = 1'b0;
        presc_wrap = 1'b0;
        presc_d    = presc_q;
        adj_rise   = 1'b0;
        rep_hit    = 1'b0;
        rep_cnt_d  = rep_cnt_q;
        adj_fire   = 1'b0;
        blink_win  = 1'b0;

        leave_set  = (state_q == ST_SET_MIN) && mode_i;
        presc_wrap = (presc_q == PW'(CLK_HZ - 1));
        // Leaving set mode restarts the second so the next tick is a full period away
        presc_d    = (leave_set || presc_wrap) ? '0 : presc_q + PW'(1);

        adj_rise   = adj_i && !adj_q;
        rep_hit    = (rep_cnt_q == RW'(REPEAT_CYC - 1));
        if (!adj_i || adj_rise || rep_hit) begin
            rep_cnt_d = '0;
        end else begin
            rep_cnt_d = rep_cnt_q + RW'(1);
        end
        // A mode press in the same cycle takes priority over an adjust step
        adj_fire   = adj_i && !mode_i && (adj_rise || rep_hit);
        blink_win  = (presc_d < PW'(CLK_HZ / 2));
    end

    // Mode FSM and all registered outputs
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= ST_RUN;
            presc_q   <= '0;
            rep_cnt_q <= '0;
            adj_q     <= 1'b0;
            tick_q    <= 1'b0;
            sec_clr_q <= 1'b0;
            hr_adj_q  <= 1'b0;
            min_adj_q <= 1'b0;
            blink_q   <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            rep_cnt_q <= rep_cnt_d;
            adj_q     <= adj_i;
            tick_q    <= presc_wrap && !leave_set;
            sec_clr_q <= 1'b0;
            hr_adj_q  <= 1'b0;
            min_adj_q <= 1'b0;
            blink_q   <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (mode_i) begin
                        state_q <= ST_SET_HR;
                        blink_q <= blink_win;
                    end
                end
                ST_SET_HR: begin
                    hr_adj_q <= adj_fire;
                    blink_q  <= blink_win;
                    if (mode_i) begin
                        state_q <= ST_SET_MIN;
                    end
                end
                ST_SET_MIN: begin
                    min_adj_q <= adj_fire;
                    if (mode_i) begin
                        state_q   <= ST_RUN;
                        sec_clr_q <= 1'b1;
                    end else begin
                        blink_q   <= blink_win;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    // Carries pass straight through only while running; set mode uses adjust pulses
    assign sec_inc_o = (state_q == ST_RUN) && tick_q;
    assign min_inc_o = ((state_q == ST_RUN) && sec_ovf_i) || min_adj_q;
    assign hr_inc_o  = ((state_q == ST_RUN) && min_ovf_i) || hr_adj_q;
    assign sec_clr_o = sec_clr_q;
    assign tick_o    = tick_q;
    assign state_o   = state_q;
    assign blink_o   = blink_q;

endmodule
